// File: rtl/ysyx_22050133_axi_pkg.sv
// Shared widths, helpers and FSM encodings for the AXI round-robin arbiter.
// Payload widths depend on bus parameters, so helpers compute them per instance.
package ysyx_22050133_axi_pkg;

  function automatic int awp_w(input int addr_w);
    return addr_w + 13;
  endfunction

  function automatic int wp_w(input int data_w);
    return data_w + data_w / 8 + 1;
  endfunction

  function automatic int rp_w(input int data_w);
    return data_w + 3;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Widths for the default configuration (2 masters, 32-bit addr, 64-bit data)
  localparam int AWP   = awp_w(32);
  localparam int WP    = wp_w(64);
  localparam int RP    = rp_w(64);
  localparam int IDX_W = idx_w(2);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } r_state_e;

endpackage

// File: rtl/ysyx_22050133_rr_pick.sv
// Combinational grant picker: round-robin after ptr, or lowest index when rr_en=0.
module ysyx_22050133_rr_pick #(
  parameter int NUM_M = 2,
  parameter int IDX_W = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_en,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [2*NUM_M-1:0] req_dbl;
  logic [2*NUM_M-1:0] mask_dbl;
  logic [2*NUM_M-1:0] cand;

  always_comb begin
    req_dbl  = {req, req};
    mask_dbl = '0;
    for (int j = 0; j < 2*NUM_M; j++) begin
      mask_dbl[j] = (j > int'(ptr));
    end
    cand = rr_en ? (req_dbl & mask_dbl) : {{NUM_M{1'b0}}, req};
    // Scanning downward leaves the lowest candidate in gnt_idx.
    gnt_idx = '0;
    for (int j = 2*NUM_M-1; j >= 0; j--) begin
      if (cand[j]) gnt_idx = IDX_W'(j % NUM_M);
    end
  end

  assign any = |req;

endmodule

// File: rtl/ysyx_22050133_axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter; read and write each hold a grant for a whole transaction.
//   state  | meaning
//   W_IDLE | no write owner, arbitrate AW requests
//   W_ADDR | forward AW of granted master
//   W_DATA | forward W beats until last
//   W_RESP | forward B to owner, then release
//   R_IDLE | no read owner, arbitrate AR requests
//   R_ADDR | forward AR of granted master
//   R_DATA | forward R beats until last, then release
module ysyx_22050133_axi_rr_arbiter
  import ysyx_22050133_axi_pkg::*;
#(
  parameter int NUM_M          = 2,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter bit RR_EN          = 1'b1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_M-1:0]                             s_aw_valid_i,
  output logic [NUM_M-1:0]                             s_aw_ready_o,
  input  logic [NUM_M*awp_w(AXI_ADDR_WIDTH)-1:0]       s_aw_pld_i,
  input  logic [NUM_M-1:0]                             s_w_valid_i,
  output logic [NUM_M-1:0]                             s_w_ready_o,
  input  logic [NUM_M*wp_w(AXI_DATA_WIDTH)-1:0]        s_w_pld_i,
  output logic [NUM_M-1:0]                             s_b_valid_o,
  input  logic [NUM_M-1:0]                             s_b_ready_i,
  output logic [1:0]                                   s_b_resp_o,
  input  logic [NUM_M-1:0]                             s_ar_valid_i,
  output logic [NUM_M-1:0]                             s_ar_ready_o,
  input  logic [NUM_M*awp_w(AXI_ADDR_WIDTH)-1:0]       s_ar_pld_i,
  output logic [NUM_M-1:0]                             s_r_valid_o,
  input  logic [NUM_M-1:0]                             s_r_ready_i,
  output logic [rp_w(AXI_DATA_WIDTH)-1:0]              s_r_pld_o,
  output logic                                         m_aw_valid_o,
  input  logic                                         m_aw_ready_i,
  output logic [AXI_ID_WIDTH-1:0]                      m_aw_id_o,
  output logic [awp_w(AXI_ADDR_WIDTH)-1:0]             m_aw_pld_o,
  output logic                                         m_w_valid_o,
  input  logic                                         m_w_ready_i,
  output logic [wp_w(AXI_DATA_WIDTH)-1:0]              m_w_pld_o,
  input  logic                                         m_b_valid_i,
  output logic                                         m_b_ready_o,
  input  logic [1:0]                                   m_b_resp_i,
  output logic                                         m_ar_valid_o,
  input  logic                                         m_ar_ready_i,
  output logic [AXI_ID_WIDTH-1:0]                      m_ar_id_o,
  output logic [awp_w(AXI_ADDR_WIDTH)-1:0]             m_ar_pld_o,
  input  logic                                         m_r_valid_i,
  output logic                                         m_r_ready_o,
  input  logic [rp_w(AXI_DATA_WIDTH)-1:0]              m_r_pld_i
);

  localparam int L_AWP = awp_w(AXI_ADDR_WIDTH);
  localparam int L_WP  = wp_w(AXI_DATA_WIDTH);
  localparam int L_IW  = idx_w(NUM_M);

  w_state_e        w_q, w_d;
  r_state_e        r_q, r_d;
  logic [L_IW-1:0] wg_q, wg_d, wptr_q, wptr_d;
  logic [L_IW-1:0] rg_q, rg_d, rptr_q, rptr_d;
  logic [L_IW-1:0] w_pick, r_pick;
  logic            w_any, r_any;

  ysyx_22050133_rr_pick #(.NUM_M(NUM_M), .IDX_W(L_IW)) u_w_pick (
    .req    (s_aw_valid_i),
    .ptr    (wptr_q),
    .rr_en  (RR_EN),
    .gnt_idx(w_pick),
    .any    (w_any)
  );

  ysyx_22050133_rr_pick #(.NUM_M(NUM_M), .IDX_W(L_IW)) u_r_pick (
    .req    (s_ar_valid_i),
    .ptr    (rptr_q),
    .rr_en  (RR_EN),
    .gnt_idx(r_pick),
    .any    (r_any)
  );

  // Payloads follow the registered grant only, keeping valid off the grant path.
  assign m_aw_pld_o = s_aw_pld_i[int'(wg_q)*L_AWP +: L_AWP];
  assign m_w_pld_o  = s_w_pld_i[int'(wg_q)*L_WP +: L_WP];
  assign m_ar_pld_o = s_ar_pld_i[int'(rg_q)*L_AWP +: L_AWP];
  assign m_aw_id_o  = AXI_ID_WIDTH'(wg_q);
  assign m_ar_id_o  = AXI_ID_WIDTH'(rg_q);
  assign s_b_resp_o = m_b_resp_i;
  assign s_r_pld_o  = m_r_pld_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= W_IDLE;
      r_q    <= R_IDLE;
      wg_q   <= '0;
      rg_q   <= '0;
      wptr_q <= L_IW'(NUM_M-1);
      rptr_q <= L_IW'(NUM_M-1);
    end else begin
      w_q    <= w_d;
      r_q    <= r_d;
      wg_q   <= wg_d;
      rg_q   <= rg_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_comb begin
    w_d          = w_q;
    wg_d         = wg_q;
    wptr_d       = wptr_q;
    s_aw_ready_o = '0;
    s_w_ready_o  = '0;
    s_b_valid_o  = '0;
    m_aw_valid_o = 1'b0;
    m_w_valid_o  = 1'b0;
    m_b_ready_o  = 1'b0;
    if (!rst) begin
      case (w_q)
        W_IDLE: begin
          if (w_any) begin
            w_d  = W_ADDR;
            wg_d = w_pick;
          end
        end
        W_ADDR: begin
          m_aw_valid_o       = s_aw_valid_i[wg_q];
          s_aw_ready_o[wg_q] = m_aw_ready_i;
          if (s_aw_valid_i[wg_q] && m_aw_ready_i) w_d = W_DATA;
        end
        W_DATA: begin
          m_w_valid_o       = s_w_valid_i[wg_q];
          s_w_ready_o[wg_q] = m_w_ready_i;
          if (s_w_valid_i[wg_q] && m_w_ready_i && m_w_pld_o[0]) w_d = W_RESP;
        end
        W_RESP: begin
          s_b_valid_o[wg_q] = m_b_valid_i;
          m_b_ready_o       = s_b_ready_i[wg_q];
          if (m_b_valid_i && s_b_ready_i[wg_q]) begin
            w_d    = W_IDLE;
            wptr_d = wg_q;
          end
        end
        default: w_d = W_IDLE;
      endcase
    end
  end

  always_comb begin
    r_d          = r_q;
    rg_d         = rg_q;
    rptr_d       = rptr_q;
    s_ar_ready_o = '0;
    s_r_valid_o  = '0;
    m_ar_valid_o = 1'b0;
    m_r_ready_o  = 1'b0;
    if (!rst) begin
      case (r_q)
        R_IDLE: begin
          if (r_any) begin
            r_d  = R_ADDR;
            rg_d = r_pick;
          end
        end
        R_ADDR: begin
          m_ar_valid_o       = s_ar_valid_i[rg_q];
          s_ar_ready_o[rg_q] = m_ar_ready_i;
          if (s_ar_valid_i[rg_q] && m_ar_ready_i) r_d = R_DATA;
        end
        R_DATA: begin
          s_r_valid_o[rg_q] = m_r_valid_i;
          m_r_ready_o       = s_r_ready_i[rg_q];
          if (m_r_valid_i && s_r_ready_i[rg_q] && m_r_pld_i[0]) begin
            r_d    = R_IDLE;
            rptr_d = rg_q;
          end
        end
        default: r_d = R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_22050133_axi_rr_arbiter.md
Name: ysyx_22050133_axi_rr_arbiter

Overview:
N-master to 1-slave AXI4 arbiter that sits between the core's memory clients (IF, MEM, DMA/cache refill) and the single AXI master port.
- Read and write directions are arbitrated independently, each with a registered round-robin (or fixed-priority) grant.
- A grant is held for a whole transaction: address handshake, all data beats, and the B response for writes.
- The granted master's index is driven on the AXI ID.

Parameters:
NUM_M, 2, number of upstream masters, at least 2; clog2(NUM_M) must be ≤ AXI_ID_WIDTH.
AXI_DATA_WIDTH, 64, data bus width.
AXI_ADDR_WIDTH, 32, address width.
AXI_ID_WIDTH, 4, AXI ID width.
RR_EN, 1, 1 = round-robin; 0 = fixed priority with the lowest index winning.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_aw_valid_i  in  NUM_M  per-master AW valid
s_aw_ready_o  out  NUM_M  per-master AW ready
s_aw_pld_i  in  NUM_M*AWP  per-master {addr,len[7:0],size[2:0],burst[1:0]}, AWP=ADDR+13
s_w_valid_i  in  NUM_M  per-master W valid
s_w_ready_o  out  NUM_M  per-master W ready
s_w_pld_i  in  NUM_M*WP  per-master {data,strb,last}, WP=DATA+DATA/8+1
s_b_valid_o  out  NUM_M  per-master B valid
s_b_ready_i  in  NUM_M  per-master B ready
s_b_resp_o  out  2  B resp, broadcast to all masters
s_ar_valid_i  in  NUM_M  per-master AR valid
s_ar_ready_o  out  NUM_M  per-master AR ready
s_ar_pld_i  in  NUM_M*AWP  per-master AR payload, same packing as AW
s_r_valid_o  out  NUM_M  per-master R valid
s_r_ready_i  in  NUM_M  per-master R ready
s_r_pld_o  out  DATA+3  {data,resp,last}, broadcast to all masters
m_aw_valid_o / m_aw_ready_i / m_aw_id_o / m_aw_pld_o  out/in/out/out  1/1/ID/AWP  downstream AW channel
m_w_valid_o / m_w_ready_i / m_w_pld_o  out/in/out  1/1/WP  downstream W channel
m_b_valid_i / m_b_ready_o / m_b_resp_i  in/out/in  1/1/2  downstream B channel
m_ar_valid_o / m_ar_ready_i / m_ar_id_o / m_ar_pld_o  out/in/out/out  1/1/ID/AWP  downstream AR channel
m_r_valid_i / m_r_ready_o / m_r_pld_i  in/out/in  1/1/DATA+3  downstream R channel

Behaviour:
Clock and reset:
- Clock clk; reset rst, synchronous, active-high.
- Reset puts both FSMs in IDLE and sets both grant pointers to NUM_M-1, so master 0 wins first.
- Reset forces every valid/ready output to 0, while rst is high and one cycle after. m_*_id_o resets to 0.
- Reset mid-transaction drops the transaction with no drain. The downstream slave is reset on the same rst.

Write FSM: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE: if any s_aw_valid_i bit is set, pick g and go to W_ADDR next cycle. Arbitration latency is exactly 1 cycle.
- Pick rule, RR_EN=1: first requesting index after the pointer, wrapping modulo NUM_M.
- Pick rule, RR_EN=0: lowest requesting index.
- W_ADDR: m_aw_valid_o = s_aw_valid_i[g]; s_aw_ready_o[g] = m_aw_ready_i; m_aw_pld_o = slice g; m_aw_id_o = g zero-extended.
- W_ADDR ends on the AW handshake -> W_DATA.
- W_DATA: W is forwarded from master g; the state ends on a W handshake with last=1 -> W_RESP.
- W_RESP: s_b_valid_o[g] = m_b_valid_i; m_b_ready_o = s_b_ready_i[g]. On the B handshake -> W_IDLE and pointer <= g.
- s_w_ready_o is 0 outside W_DATA, even if W is presented before AW.

Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
- Uses the same pick rule and an independent pointer.
- R_DATA: s_r_valid_o[g] = m_r_valid_i; m_r_ready_o = s_r_ready_i[g].
- R_DATA ends on an R handshake with last=1 -> R_IDLE, pointer <= g.

Gating and muxing:
- Non-granted masters always see ready=0 and valid=0.
- Every m_*_valid_o and m_*_ready_o is 0 in states that do not own that channel.
- Payload muxes use the registered g only, never a combinational pick, so there is no valid-to-grant combinational path.

Boundary conditions:
- All NUM_M masters requesting in the same cycle: grants rotate 0,1,...,NUM_M-1 with RR_EN=1.
- Read and write transactions proceed concurrently, including from the same master.
- A master that deasserts valid in ADDR (protocol violation) keeps the grant; the FSM holds in ADDR.
- Burst length is tracked only by last; no beat counter is kept.
- m_*_id_i is not routed on. Only one transaction per direction is outstanding.

Decomposition:
- Package ysyx_22050133_axi_pkg holds: payload width localparams (AWP, WP, RP), FSM state encodings, and IDX_W = $clog2(NUM_M).
- Sub-module ysyx_22050133_rr_pick is instantiated twice (read, write).
  - Inputs: req[NUM_M], ptr, rr_en.
  - Outputs: gnt_idx, any.
  - Purely combinational: double-width mask-and-priority-encode.

Test Plan:
- NUM_M=2, master1 AR only, len=3 -> m_ar_id_o=1; 4 R beats reach master1 only; s_r_valid_o[0]=0 throughout; back in IDLE the cycle after the last handshake.
- NUM_M=4, all AW valid held high, single-beat writes -> grant order 0,1,2,3,0; each B reaches only its owner.
- RR_EN=0, NUM_M=4, masters 2 and 3 requesting continuously -> master 2 granted every time.
- Master0 write with W valid asserted before AW handshake -> s_w_ready_o[0]=0 until W_DATA; data passes intact; m_b_ready_o follows s_b_ready_i[0].
- Concurrent master0 read (len=7) and master1 write (len=1) -> both complete with no cross-routing and no stall between directions.
- rst asserted in R_DATA after beat 2 of 4 -> all valid/ready outputs 0 next cycle; first post-reset request from master 0 granted.
